pifo_calendar_v0_2: RTL and testbench
=====================================

// Module: pifo_calendar_v0_2
// PURPOSE
//  Parametrised shift-register PIFO calendar, successor to the root-only v0.1 calendar.
//  Keeps up to DEPTH {rank,data} entries sorted by ascending rank (FIFO among equal ranks) and presents the head on an AXI-Stream-style master port.
//  Adds valid/ready handshakes, simultaneous insert+pop, occupancy and full/empty flags, drop policy/counter, registered CPU slot read.
//  Sits between the scheduler rank computation and the output-queue buffer manager.
// PARAMETERS
//  DEPTH        64  number of calendar slots (>=2)
//  INDEX_WIDTH  6   clog2(DEPTH); width of cpu_in_addr
//  RANK_WIDTH   16  rank width, unsigned; lower rank = earlier service
//  DATA_WIDTH   12  payload width (buffer address)
//  DROP_MODE    0   0: back-pressure when full; 1: always ready, evict tail or drop new when full
// PORTS
//  clk             in   1                   clock, all logic rising-edge
//  rst             in   1                   synchronous reset, active-high
//  s_axis_tdata    in   DATA_WIDTH          insert payload
//  s_axis_trank    in   RANK_WIDTH          insert rank
//  s_axis_tvalid   in   1                   insert request
//  s_axis_tready   out  1                   insert accepted when tvalid&tready
//  m_axis_tdata    out  DATA_WIDTH          head payload
//  m_axis_trank    out  RANK_WIDTH          head rank
//  m_axis_tvalid   out  1                   head valid (calendar non-empty)
//  m_axis_tready   in   1                   pop when tvalid&tready
//  count           out  INDEX_WIDTH+1       occupancy 0..DEPTH
//  full / empty    out  1                   count==DEPTH / count==0
//  drop_pulse      out  1                   one-cycle pulse: an entry was discarded (registered)
//  drop_count      out  32                  saturating discard counter
//  cpu_in_valid    in   1                   CPU slot read request
//  cpu_in_addr     in   INDEX_WIDTH         slot index, 0 = head
//  cpu_out_valid   out  1                   read result valid
//  cpu_out_result  out  1+RANK_WIDTH+DATA_WIDTH  {valid,rank,data} of slot
// BEHAVIOUR
//  - Reset: all slots invalid, count=0, empty=1, full=0, m_axis_tvalid=0, drop_pulse=0, drop_count=0, cpu_out_valid=0, cpu_out_result=0. Reset mid-operation discards all contents, no drop counted.
//  - Slot i valid iff i<count; valid slots contiguous from 0; m_axis_* = slot 0 (registered, no comb path from s_axis).
//  - Insert position p = first valid slot with rank > new rank, else count (strict > gives FIFO order on ties).
//  - Insert only: slots >=p shift toward tail, new at p, count+1. Visible at head earliest next cycle.
//  - Pop only: all slots shift toward head, count-1. Head stable while tready=0.
//  - Insert+pop same cycle: p computed on pre-pop array; after shift new lands at max(p-1,0); count unchanged.
//  - Pop when empty impossible (tvalid=0); tready ignored.
//  - DROP_MODE 0: s_axis_tready = !full | (m_axis_tvalid & m_axis_tready). Never drops.
//  - DROP_MODE 1: s_axis_tready=1. Full, no pop: new rank < tail rank -> tail evicted, new inserted; else new discarded. Either case drop_pulse next cycle, drop_count+1 (sticks at 2^32-1).
//  - cpu_out_valid = cpu_in_valid delayed 1 cycle; result = slot content sampled same edge as request; slot>=count reads valid bit 0.
// TESTING
//  1 Insert (r5,d1),(r3,d2),(r9,d3),(r3,d4), then pop x4 -> d2,d4,d1,d3; empty=1 after last.
//  2 DROP_MODE0: fill 64 -> full=1, tready=0; insert+pop same cycle -> accepted, count stays 64.
//  3 DROP_MODE1 full, tail r100: insert r50 -> tail evicted, drop_count=1; insert r200 -> dropped, drop_count=2.
//  4 count=3, head r10; insert r2 with pop -> next cycle head r2, count=3.
//  5 m_axis_tready=0 for 5 cycles with inserts of higher rank -> head unchanged; reset mid-stream -> count=0 next cycle.
//  6 CPU read addr 1 with 3 entries -> cpu_out_valid next cycle, result {1,rank1,data1}; addr 5 -> valid bit 0.

Source files
------------

// File: rtl/pifo_calendar_v0_2_if.sv
// pifo_calendar_v0_2_if
//   Stream bundle that carries one {rank,data} item per handshake.
//   Ports (signals):
//     tdata   payload (buffer address)
//     trank   unsigned rank, lower rank is served earlier
//     tvalid  item present
//     tready  item accepted when tvalid & tready are both high on a rising clock edge
//   Modports:
//     master  drives tdata/trank/tvalid and samples tready
//     slave   samples tdata/trank/tvalid and drives tready
//   Handshake: a transfer happens on every rising edge where tvalid & tready.
//   The master keeps tdata/trank stable while tvalid is high and tready is low.
interface pifo_calendar_v0_2_if #(
    parameter int RANK_WIDTH = 16,
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [RANK_WIDTH-1:0] trank;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output trank, output tvalid, input tready);
    modport slave  (input tdata, input trank, input tvalid, output tready);
endinterface

// File: rtl/pifo_calendar_v0_2.sv
// pifo_calendar_v0_2
//   Shift-register PIFO calendar. Holds up to DEPTH {rank,data} entries sorted
//   by ascending rank (FIFO among equal ranks); slot 0 is the head and is
//   presented on m_axis.
//   Ports:
//     clk, rst         rising-edge clock, synchronous active-high reset
//     s_axis (slave)   insert side: tdata/trank/tvalid in, tready out
//     m_axis (master)  head side: tdata/trank/tvalid out, tready in (pop)
//     count/full/empty occupancy 0..DEPTH and its flags
//     drop_pulse       one-cycle pulse after an entry was discarded
//     drop_count       saturating discard counter
//     cpu_in_valid/cpu_in_addr      slot read request (0 = head)
//     cpu_out_valid/cpu_out_result  {valid,rank,data} one cycle later
module pifo_calendar_v0_2 #(
    parameter int DEPTH       = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int RANK_WIDTH  = 16,
    parameter int DATA_WIDTH  = 12,
    parameter int DROP_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    pifo_calendar_v0_2_if.slave                s_axis,
    pifo_calendar_v0_2_if.master               m_axis,
    output logic [INDEX_WIDTH:0]               count,
    output logic                               full,
    output logic                               empty,
    output logic                               drop_pulse,
    output logic [31:0]                        drop_count,
    input  logic                               cpu_in_valid,
    input  logic [INDEX_WIDTH-1:0]             cpu_in_addr,
    output logic                               cpu_out_valid,
    output logic [RANK_WIDTH+DATA_WIDTH:0]     cpu_out_result
);
    localparam int CW = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [RANK_WIDTH-1:0] rank_q [DEPTH];
    logic [RANK_WIDTH-1:0] rank_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [31:0]           drop_count_q, drop_count_d;
    logic                  cpu_out_valid_q, cpu_out_valid_d;
    logic [RANK_WIDTH+DATA_WIDTH:0] cpu_out_result_q, cpu_out_result_d;

    logic [RANK_WIDTH-1:0] new_rank;
    logic [DATA_WIDTH-1:0] new_data;
    logic                  full_w, pop, tready_w, hs, do_ins, drop_now;

    // ge_p[i] = slot i is at or after the insert position p. Bit DEPTH is
    // always set so p == DEPTH when every slot is valid and ranked <= new.
    logic [DEPTH:0]        ge_p;
    logic [DEPTH-1:0]      ge_prev;
    logic [RANK_WIDTH-1:0] ext_rank [DEPTH+1];
    logic [DATA_WIDTH-1:0] ext_data [DEPTH+1];
    logic [RANK_WIDTH-1:0] prv_rank [DEPTH];
    logic [DATA_WIDTH-1:0] prv_data [DEPTH];

    assign new_rank = s_axis.trank;
    assign new_data = s_axis.tdata;
    assign full_w   = (count_q == DEPTH_C);
    assign pop      = (count_q != '0) && m_axis.tready;

    // Acceptance and drop decision. In DROP_MODE 1 a full calendar with no
    // pop either evicts the tail (new rank strictly smaller) or discards new.
    always_comb begin
        tready_w = (DROP_MODE != 0) ? 1'b1 : (!full_w || pop);
        hs       = s_axis.tvalid && tready_w;
        do_ins   = hs;
        drop_now = 1'b0;
        if ((DROP_MODE != 0) && full_w && !pop && hs) begin
            drop_now = 1'b1;
            do_ins   = (new_rank < rank_q[DEPTH-1]);
        end
    end

    // Insert-position mask plus neighbour views of the slot array.
    always_comb begin
        ge_p        = '0;
        ge_p[DEPTH] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ge_p[i]     = (CW'(i) >= count_q) || (rank_q[i] > new_rank);
            ext_rank[i] = rank_q[i];
            ext_data[i] = data_q[i];
        end
        ext_rank[DEPTH] = '0;
        ext_data[DEPTH] = '0;
        ge_prev     = {ge_p[DEPTH-2:0], 1'b0};
        prv_rank[0] = new_rank;
        prv_data[0] = new_data;
        for (int i = 1; i < DEPTH; i++) begin
            prv_rank[i] = rank_q[i-1];
            prv_data[i] = data_q[i-1];
        end
    end

    always_comb begin
        rank_d = rank_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_ins && pop) begin
                // Old head leaves; new lands at max(p-1,0), slots before it
                // move up one, slots after it stay put.
                if (!ge_p[i+1]) begin
                    rank_d[i] = ext_rank[i+1];
                    data_d[i] = ext_data[i+1];
                end else if (i == 0 || !ge_p[i]) begin
                    rank_d[i] = new_rank;
                    data_d[i] = new_data;
                end
            end else if (do_ins) begin
                // Slots >= p shift toward the tail; a full array loses its tail.
                if (ge_p[i]) begin
                    rank_d[i] = ge_prev[i] ? prv_rank[i] : new_rank;
                    data_d[i] = ge_prev[i] ? prv_data[i] : new_data;
                end
            end else if (pop) begin
                rank_d[i] = ext_rank[i+1];
                data_d[i] = ext_data[i+1];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_ins && !pop && !full_w) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_ins) begin
            count_d = count_q - 1'b1;
        end
        drop_pulse_d = drop_now;
        drop_count_d = drop_count_q;
        if (drop_now && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 32'd1;
        end
        cpu_out_valid_d  = cpu_in_valid;
        cpu_out_result_d = cpu_out_result_q;
        if (cpu_in_valid) begin
            if ({1'b0, cpu_in_addr} < count_q) begin
                cpu_out_result_d = {1'b1, rank_q[cpu_in_addr], data_q[cpu_in_addr]};
            end else begin
                cpu_out_result_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rank_q[i] <= '0;
                data_q[i] <= '0;
            end
            count_q          <= '0;
            drop_pulse_q     <= 1'b0;
            drop_count_q     <= '0;
            cpu_out_valid_q  <= 1'b0;
            cpu_out_result_q <= '0;
        end else begin
            rank_q           <= rank_d;
            data_q           <= data_d;
            count_q          <= count_d;
            drop_pulse_q     <= drop_pulse_d;
            drop_count_q     <= drop_count_d;
            cpu_out_valid_q  <= cpu_out_valid_d;
            cpu_out_result_q <= cpu_out_result_d;
        end
    end

    assign s_axis.tready  = tready_w;
    assign m_axis.tdata   = data_q[0];
    assign m_axis.trank   = rank_q[0];
    assign m_axis.tvalid  = (count_q != '0);
    assign count          = count_q;
    assign full           = full_w;
    assign empty          = (count_q == '0);
    assign drop_pulse     = drop_pulse_q;
    assign drop_count     = drop_count_q;
    assign cpu_out_valid  = cpu_out_valid_q;
    assign cpu_out_result = cpu_out_result_q;
endmodule

// File: tb/tb_pifo_calendar_v0_2.sv
// tb_pifo_calendar_v0_2
//   Directed bench for two calendar instances: u_bp (back-pressure, DROP_MODE 0)
//   and u_dr (drop, DROP_MODE 1). Inputs change 1 ns after a rising edge and
//   outputs are sampled at that same point, away from the active edge.
module tb_pifo_calendar_v0_2;
    localparam int DEPTH = 64;
    localparam int IW    = 6;
    localparam int RW    = 16;
    localparam int DW    = 12;
    localparam int RES_W = 1 + RW + DW;

    logic clk;
    logic rst;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pifo_calendar_v0_2_if #(.RANK_WIDTH(RW), .DATA_WIDTH(DW)) s0 ();
    pifo_calendar_v0_2_if #(.RANK_WIDTH(RW), .DATA_WIDTH(DW)) m0 ();
    pifo_calendar_v0_2_if #(.RANK_WIDTH(RW), .DATA_WIDTH(DW)) s1 ();
    pifo_calendar_v0_2_if #(.RANK_WIDTH(RW), .DATA_WIDTH(DW)) m1 ();

    logic [IW:0]      count0, count1;
    logic             full0, full1, empty0, empty1, dp0, dp1;
    logic [31:0]      dc0, dc1;
    logic             ci_v0, ci_v1, cv0, cv1;
    logic [IW-1:0]    ci_a0, ci_a1;
    logic [RES_W-1:0] cr0, cr1;

    pifo_calendar_v0_2 #(.DEPTH(DEPTH), .INDEX_WIDTH(IW), .RANK_WIDTH(RW),
                         .DATA_WIDTH(DW), .DROP_MODE(0)) u_bp (
        .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
        .count(count0), .full(full0), .empty(empty0),
        .drop_pulse(dp0), .drop_count(dc0),
        .cpu_in_valid(ci_v0), .cpu_in_addr(ci_a0),
        .cpu_out_valid(cv0), .cpu_out_result(cr0)
    );

    pifo_calendar_v0_2 #(.DEPTH(DEPTH), .INDEX_WIDTH(IW), .RANK_WIDTH(RW),
                         .DATA_WIDTH(DW), .DROP_MODE(1)) u_dr (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
        .count(count1), .full(full1), .empty(empty1),
        .drop_pulse(dp1), .drop_count(dc1),
        .cpu_in_valid(ci_v1), .cpu_in_addr(ci_a1),
        .cpu_out_valid(cv1), .cpu_out_result(cr1)
    );

    // ---------------- scoreboard ----------------
    int vectors;
    int miscompares;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins0(input logic [RW-1:0] r, input logic [DW-1:0] d);
        s0.tvalid = 1'b1;
        s0.trank  = r;
        s0.tdata  = d;
        tick();
    endtask

    task automatic ins1(input logic [RW-1:0] r, input logic [DW-1:0] d);
        s1.tvalid = 1'b1;
        s1.trank  = r;
        s1.tdata  = d;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        s0.tvalid = 1'b0; s0.trank = '0; s0.tdata = '0; m0.tready = 1'b0;
        s1.tvalid = 1'b0; s1.trank = '0; s1.tdata = '0; m1.tready = 1'b0;
        ci_v0 = 1'b0; ci_a0 = '0; ci_v1 = 1'b0; ci_a1 = '0;
        tick();
        tick();

        // Reset state
        check("rst_count0", count0, 0);
        check("rst_empty0", empty0, 1);
        check("rst_full0", full0, 0);
        check("rst_tvalid0", m0.tvalid, 0);
        check("rst_dp0", dp0, 0);
        check("rst_dc0", dc0, 0);
        check("rst_cv0", cv0, 0);
        check("rst_cr0", cr0, 0);
        check("rst_count1", count1, 0);
        check("rst_dc1", dc1, 0);
        rst = 1'b0;
        tick();

        // Sorted insert with FIFO ties, then drain in order
        ins0(16'd5, 12'd1);
        ins0(16'd3, 12'd2);
        ins0(16'd9, 12'd3);
        ins0(16'd3, 12'd4);
        s0.tvalid = 1'b0;
        check("t1_count", count0, 4);
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd1);
        exp_q.push_back(12'd3);
        m0.tready = 1'b1;
        while (exp_q.size() > 0) begin
            check("t1_head_valid", m0.tvalid, 1);
            check("t1_head_data", m0.tdata, exp_q.pop_front());
            tick();
        end
        m0.tready = 1'b0;
        check("t1_empty", empty0, 1);
        check("t1_count0", count0, 0);
        check("t1_tvalid", m0.tvalid, 0);

        // CPU slot reads with three entries
        ins0(16'd10, 12'd7);
        ins0(16'd20, 12'd8);
        ins0(16'd30, 12'd9);
        s0.tvalid = 1'b0;
        check("t6_count", count0, 3);
        ci_v0 = 1'b1;
        ci_a0 = 6'd1;
        tick();
        check("t6_cv_a1", cv0, 1);
        check("t6_cr_a1", cr0, {1'b1, 16'd20, 12'd8});
        ci_a0 = 6'd5;
        tick();
        check("t6_cv_a5", cv0, 1);
        check("t6_validbit_a5", cr0[RES_W-1], 0);
        ci_v0 = 1'b0;
        tick();
        check("t6_cv_idle", cv0, 0);

        // Insert lower than head together with a pop
        s0.tvalid = 1'b1; s0.trank = 16'd2; s0.tdata = 12'd5;
        m0.tready = 1'b1;
        tick();
        s0.tvalid = 1'b0;
        m0.tready = 1'b0;
        check("t4_head_rank", m0.trank, 2);
        check("t4_head_data", m0.tdata, 5);
        check("t4_count", count0, 3);

        // Head stable while not popped; reset mid-stream
        for (int k = 0; k < 5; k++) begin
            ins0(16'(40 + k), 12'(k));
            check("t5_head_rank", m0.trank, 2);
            check("t5_count", count0, 4 + k);
        end
        rst = 1'b1;
        tick();
        check("t5_rst_count", count0, 0);
        check("t5_rst_empty", empty0, 1);
        rst = 1'b0;
        s0.tvalid = 1'b0;
        tick();
        check("t5_post_count", count0, 0);
        check("t5_post_dc", dc0, 0);

        // Back-pressure: fill, then insert+pop while full
        for (int i = 0; i < DEPTH; i++) begin
            ins0(16'(i), 12'(i));
        end
        s0.tvalid = 1'b0;
        check("t2_full", full0, 1);
        check("t2_count", count0, DEPTH);
        check("t2_tready_full", s0.tready, 0);
        s0.tvalid = 1'b1; s0.trank = 16'd1000; s0.tdata = 12'hFFF;
        m0.tready = 1'b1;
        #1;
        check("t2_tready_pop", s0.tready, 1);
        tick();
        s0.tvalid = 1'b0;
        m0.tready = 1'b0;
        check("t2_count_after", count0, DEPTH);
        check("t2_full_after", full0, 1);
        check("t2_head_rank", m0.trank, 1);
        check("t2_dc", dc0, 0);

        // Drop mode: tail eviction, then discard of new entry
        for (int i = 0; i < DEPTH; i++) begin
            ins1((i == DEPTH - 1) ? 16'd100 : 16'(i), 12'(i));
        end
        s1.tvalid = 1'b0;
        check("t3_full", full1, 1);
        check("t3_tready", s1.tready, 1);
        ins1(16'd50, 12'hABC);
        s1.tvalid = 1'b0;
        check("t3_evict_dp", dp1, 1);
        check("t3_evict_dc", dc1, 1);
        check("t3_evict_count", count1, DEPTH);
        ins1(16'd200, 12'h0DD);
        s1.tvalid = 1'b0;
        check("t3_drop_dp", dp1, 1);
        check("t3_drop_dc", dc1, 2);
        tick();
        check("t3_dp_idle", dp1, 0);
        ci_v1 = 1'b1;
        ci_a1 = 6'd51;
        tick();
        check("t3_slot51", cr1, {1'b1, 16'd50, 12'hABC});
        ci_a1 = 6'd63;
        tick();
        check("t3_slot63", cr1, {1'b1, 16'd62, 12'd62});
        ci_v1 = 1'b0;
        tick();

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
